// File: rtl/heartbeat_display.sv
// Heartbeat and activity-pattern driver for an N-digit active-low seven-segment display.
// A prescaler paces the animation (SCROLL/BOUNCE/BLINK/HOLD); a second counter blinks the dp of digit 0.
module heartbeat_display #(
  parameter int          NUM_DIGITS          = 4,
  parameter int          PULSE_COUNT_MAX     = 1389000,
  parameter int          HEARTBEAT_COUNT_MAX = 262144,
  parameter logic [7:0]  SEG_ON              = 8'hBF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [1:0]              mode,
  output logic [8*NUM_DIGITS-1:0] dig,
  output logic                    tick,
  output logic                    beat
);

  localparam int PW    = $clog2(PULSE_COUNT_MAX);
  localparam int HW    = $clog2(HEARTBEAT_COUNT_MAX);
  localparam int POS_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0]    PRESC_LAST = PW'(PULSE_COUNT_MAX - 1);
  localparam logic [HW-1:0]    HB_LAST    = HW'(HEARTBEAT_COUNT_MAX - 1);
  localparam logic [POS_W-1:0] POS_LAST   = POS_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    SCROLL = 2'd0,
    BOUNCE = 2'd1,
    BLINK  = 2'd2,
    HOLD   = 2'd3
  } mode_t;

  logic [PW-1:0]           presc;
  logic [HW-1:0]           hb_cnt;
  logic [POS_W-1:0]        pos;
  logic                    dir_up;
  logic                    phase;
  mode_t                   mode_q;
  mode_t                   mode_cur;
  logic                    mode_change;
  logic [8*NUM_DIGITS-1:0] dig_next;

  assign mode_cur    = mode_t'(mode);
  // Entering HOLD freezes in place; any other change restarts the animation.
  assign mode_change = (mode_cur != mode_q) && (mode_cur != HOLD);

  always_comb begin
    dig_next = '1;
    case (mode_cur)
      SCROLL, BOUNCE: begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (pos == POS_W'(i)) dig_next[8*i +: 8] = SEG_ON;
        end
      end
      BLINK:   if (!phase) dig_next = {NUM_DIGITS{SEG_ON}};
      default: dig_next = dig;
    endcase
    dig_next[7] = ~beat;
  end

  always_ff @(posedge clk) begin
    mode_q <= mode_cur;
    if (reset) begin
      presc   <= '0;
      hb_cnt  <= '0;
      beat    <= 1'b0;
      tick    <= 1'b0;
      pos     <= '0;
      dir_up  <= 1'b1;
      phase   <= 1'b0;
      dig     <= '1;
      dig[7:0] <= SEG_ON;
    end else begin
      // The heartbeat ignores mode changes; only enable stalls it.
      if (enable) begin
        if (hb_cnt == HB_LAST) begin
          hb_cnt <= '0;
          beat   <= ~beat;
        end else begin
          hb_cnt <= hb_cnt + 1'b1;
        end
      end

      if (mode_change) begin
        presc  <= '0;
        tick   <= 1'b0;
        pos    <= '0;
        dir_up <= 1'b1;
        phase  <= 1'b0;
      end else if (!enable) begin
        tick <= 1'b0;
      end else begin
        if (presc == PRESC_LAST) begin
          presc <= '0;
          tick  <= 1'b1;
        end else begin
          presc <= presc + 1'b1;
          tick  <= 1'b0;
        end

        if (tick) begin
          case (mode_cur)
            SCROLL: pos <= (pos == POS_LAST) ? '0 : pos + 1'b1;
            BOUNCE: begin
              if (NUM_DIGITS == 1) begin
                pos <= '0;
              end else if (pos == POS_LAST) begin
                pos    <= pos - 1'b1;
                dir_up <= 1'b0;
              end else if (pos == '0) begin
                pos    <= pos + 1'b1;
                dir_up <= 1'b1;
              end else begin
                pos <= dir_up ? pos + 1'b1 : pos - 1'b1;
              end
            end
            BLINK:   phase <= ~phase;
            default: ;
          endcase
        end
      end

      dig <= dig_next;
    end
  end

endmodule
